// File: rtl/encoder_pkg.sv
// Types shared between the round-robin arbiter and the 4-to-2 encoder stage.
package encoder_pkg;

  localparam int NUM_REQ = 4;
  localparam int PTR_W   = 2;

  typedef logic [NUM_REQ-1:0] onehot_t;
  typedef logic [PTR_W-1:0]   ptr_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index of the set bit in a one-hot code; all-zeros maps to index 0.
  function automatic ptr_t onehot_to_idx(input onehot_t oh);
    ptr_t idx;
    idx = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = oh[i] ? (idx | ptr_t'(i)) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-priority picker: first set bit of req searching upward from pointer, modulo NUM_REQ.
module rr_priority_pick
  import encoder_pkg::*;
(
  input  onehot_t req,
  input  ptr_t    pointer,
  output onehot_t pick
);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [2*NUM_REQ-1:0] back_s;
  onehot_t              rot_s;
  onehot_t              rot_pick_s;

  // Rotate so pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_s      = {req, req} >> pointer;
    rot_s      = dbl_s[NUM_REQ-1:0];
    rot_pick_s = rot_s & (~rot_s + onehot_t'(1));
    back_s     = {rot_pick_s, rot_pick_s} << pointer;
    pick       = back_s[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Four-way round-robin arbiter producing a registered one-hot grant with a bounded hold tenure.
module onehot_rr_arbiter
  import encoder_pkg::onehot_t, encoder_pkg::ptr_t, encoder_pkg::arb_state_t,
         encoder_pkg::IDLE, encoder_pkg::GRANT, encoder_pkg::onehot_to_idx;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               gnt_ready,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         hold_cnt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t state_r;
  onehot_t    gnt_r;
  logic       gnt_valid_r;
  logic [7:0] hold_cnt_r;
  ptr_t       ptr_r;

  ptr_t    holder_idx_s;
  ptr_t    pick_ptr_s;
  onehot_t pick_s;
  logic    beat_s;
  logic    holder_req_s;
  logic    release_s;

  // Release detection; on release the re-pick starts just above the holder.
  always_comb begin
    holder_idx_s = onehot_to_idx(gnt_r);
    beat_s       = gnt_valid_r & gnt_ready;
    holder_req_s = |(req & gnt_r);
    release_s    = (state_r == GRANT) &
                   (~holder_req_s | (beat_s & (hold_cnt_r == HOLD_LAST)));
    if (release_s) begin
      pick_ptr_s = holder_idx_s + ptr_t'(1);
    end else begin
      pick_ptr_s = ptr_r;
    end
  end

  rr_priority_pick u_pick (
    .req     (req),
    .pointer (pick_ptr_s),
    .pick    (pick_s)
  );

  // Arbitration state, grant, tenure counter and rotate pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      gnt_r       <= 4'b0000;
      gnt_valid_r <= 1'b0;
      hold_cnt_r  <= 8'd0;
      ptr_r       <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|pick_s) begin
            gnt_r       <= pick_s;
            gnt_valid_r <= 1'b1;
            hold_cnt_r  <= 8'd0;
            state_r     <= GRANT;
          end else begin
            gnt_r       <= 4'b0000;
            gnt_valid_r <= 1'b0;
            hold_cnt_r  <= 8'd0;
          end
        end
        GRANT: begin
          if (release_s) begin
            ptr_r      <= pick_ptr_s;
            hold_cnt_r <= 8'd0;
            if (|pick_s) begin
              gnt_r       <= pick_s;
              gnt_valid_r <= 1'b1;
            end else begin
              gnt_r       <= 4'b0000;
              gnt_valid_r <= 1'b0;
              state_r     <= IDLE;
            end
          end else if (beat_s && (hold_cnt_r != HOLD_LAST)) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= 4'b0000;
          gnt_valid_r <= 1'b0;
          hold_cnt_r  <= 8'd0;
          ptr_r       <= 2'd0;
        end
      endcase
    end
  end

  assign gnt_valid = gnt_valid_r;
  assign gnt       = gnt_r;
  assign hold_cnt  = hold_cnt_r;

endmodule
